// File: rtl/rr_port_arbiter.sv
// rr_port_arbiter: four-requester round-robin arbiter for a shared pipeline port.
// One owner is registered at a time and drives a one-hot grant. The owner keeps
// the grant while its request stays high. A bounded hold time forces a handoff
// when other requesters are waiting.

module rr_port_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       grant_valid,
    output logic       preempt
);

    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    owner_q, owner_d;
    logic [3:0]    grant_q, grant_d;
    logic          preempt_q, preempt_d;

    logic [3:0]    ownerMask;
    logic [3:0]    others;
    logic [1:0]    ownerNext;

    function automatic logic [3:0] decode(input logic [1:0] id);
        return 4'b0001 << id;
    endfunction

    // First set bit of mask, searching upward from start and wrapping modulo 4.
    function automatic logic [1:0] pick(input logic [3:0] mask, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] sel;
        logic       found;
        sel   = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && mask[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign ownerMask = decode(owner_q);
    assign others    = req & ~ownerMask;
    assign ownerNext = owner_q + 2'd1;

    // Next-state arbitration: grant from idle, handoff on release, preempt on hold expiry.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        owner_d   = owner_q;
        preempt_d = 1'b0;
        grant_d   = 4'b0000;

        if (state_q == IDLE) begin
            if (req != 4'b0000) begin
                owner_d = pick(req, ptr_q);
                state_d = BUSY;
                hold_d  = '0;
            end
        end else begin
            if (!req[owner_q]) begin
                // Owner released; hand off on the same edge if anyone else waits.
                ptr_d  = ownerNext;
                hold_d = '0;
                if (others != 4'b0000) begin
                    owner_d = pick(others, ownerNext);
                end else begin
                    state_d = IDLE;
                end
            end else if (hold_q == HOLD_LAST && others != 4'b0000) begin
                // Hold budget used up with competitors pending: force a handoff.
                owner_d   = pick(others, ownerNext);
                ptr_d     = owner_d + 2'd1;
                hold_d    = '0;
                preempt_d = 1'b1;
            end else if (hold_q != HOLD_LAST) begin
                hold_d = hold_q + HW'(1);
            end
        end

        if (state_d == BUSY) begin
            grant_d = decode(owner_d);
        end
    end

    // Arbiter state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            hold_q    <= '0;
            owner_q   <= 2'd0;
            grant_q   <= 4'b0000;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            preempt_q <= preempt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = owner_q;
    assign grant_valid = (state_q == BUSY);
    assign preempt     = preempt_q;

endmodule
